// File: rtl/rcc_rst_seq_if.sv
// Reset/clock sequencer bus: per-domain requests and config in, domain controls and status out.
interface rcc_rst_seq_if #(
    parameter int unsigned NUM_DOM = 4,
    parameter int unsigned CNT_W   = 8
);
    logic [NUM_DOM-1:0]       dom_rst_req;
    logic [NUM_DOM*CNT_W-1:0] cfg_rst_dur;
    logic [NUM_DOM*CNT_W-1:0] cfg_clk_dly;
    logic [NUM_DOM-1:0]       dom_rst_n;
    logic [NUM_DOM-1:0]       dom_clk_en;
    logic [NUM_DOM-1:0]       dom_busy;
    logic                     seq_done;

    modport master (
        output dom_rst_req, cfg_rst_dur, cfg_clk_dly,
        input  dom_rst_n, dom_clk_en, dom_busy, seq_done
    );

    modport slave (
        input  dom_rst_req, cfg_rst_dur, cfg_clk_dly,
        output dom_rst_n, dom_clk_en, dom_busy, seq_done
    );
endinterface

// File: rtl/rcc_rst_seq.sv
// Chained per-domain reset/clock-enable sequencer: HOLD (in reset) -> WAIT (reset released,
// clock gated) -> RUN, each domain starting its HOLD count once its parent is running.
module rcc_rst_seq #(
    parameter int unsigned NUM_DOM      = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned RST_DURATION = 10,
    parameter int unsigned CLK_ON_DELAY = 8
) (
    input  logic         clk,
    input  logic         rst,
    rcc_rst_seq_if.slave bus
);
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } dom_state_e;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LEN = (RST_DURATION == 0) ? ONE : CNT_W'(RST_DURATION);
    localparam logic [CNT_W-1:0] DLY_LEN = (CLK_ON_DELAY == 0) ? ONE : CNT_W'(CLK_ON_DELAY);

    // A configured length of zero behaves as one cycle.
    function automatic logic [CNT_W-1:0] min_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    dom_state_e         state_q [NUM_DOM];
    dom_state_e         state_d [NUM_DOM];
    logic [CNT_W-1:0]   cnt_q   [NUM_DOM];
    logic [CNT_W-1:0]   cnt_d   [NUM_DOM];
    logic [NUM_DOM-1:0] pwr_q;
    logic [NUM_DOM-1:0] pwr_d;
    logic [NUM_DOM-1:0] rst_n_d;
    logic [NUM_DOM-1:0] clk_en_d;
    logic [NUM_DOM-1:0] busy_d;
    logic               all_run_d;

    // pwr_q marks domains not yet reloaded by a request since power-on; they use CLK_ON_DELAY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= ST_HOLD;
                cnt_q[i]   <= RST_LEN;
            end
            pwr_q <= '1;
        end else begin
            for (int i = 0; i < NUM_DOM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pwr_q <= pwr_d;
        end
    end

    // Next state per domain; a request cascades to every higher-index domain.
    always_comb begin
        logic             casc;
        logic             par_run;
        logic [CNT_W-1:0] dur;
        logic [CNT_W-1:0] dly;
        casc      = 1'b0;
        par_run   = 1'b1;
        dur       = '0;
        dly       = '0;
        pwr_d     = pwr_q;
        all_run_d = 1'b1;
        rst_n_d   = '0;
        clk_en_d  = '0;
        busy_d    = '1;
        for (int i = 0; i < NUM_DOM; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            dur  = min_one(bus.cfg_rst_dur[i*CNT_W +: CNT_W]);
            dly  = pwr_q[i] ? DLY_LEN : min_one(bus.cfg_clk_dly[i*CNT_W +: CNT_W]);
            casc = casc | bus.dom_rst_req[i];
            if (casc || (!par_run && state_q[i] != ST_HOLD)) begin
                state_d[i] = ST_HOLD;
                cnt_d[i]   = dur;
                pwr_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    ST_HOLD: begin
                        if (par_run) begin
                            if (cnt_q[i] <= ONE) begin
                                state_d[i] = ST_WAIT;
                                cnt_d[i]   = dly;
                            end else begin
                                cnt_d[i] = cnt_q[i] - ONE;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_q[i] <= ONE) begin
                            state_d[i] = ST_RUN;
                        end else begin
                            cnt_d[i] = cnt_q[i] - ONE;
                        end
                    end
                    ST_RUN: begin
                        state_d[i] = ST_RUN;
                    end
                    default: begin
                        state_d[i] = ST_HOLD;
                        cnt_d[i]   = dur;
                    end
                endcase
            end
            rst_n_d[i]  = (state_d[i] != ST_HOLD);
            clk_en_d[i] = (state_d[i] == ST_RUN);
            busy_d[i]   = (state_d[i] != ST_RUN);
            all_run_d   = all_run_d & (state_d[i] == ST_RUN);
            par_run     = (state_q[i] == ST_RUN);
        end
    end

    // Outputs registered from next state so they move on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dom_rst_n  <= '0;
            bus.dom_clk_en <= '0;
            bus.dom_busy   <= '1;
            bus.seq_done   <= 1'b0;
        end else begin
            bus.dom_rst_n  <= rst_n_d;
            bus.dom_clk_en <= clk_en_d;
            bus.dom_busy   <= busy_d;
            bus.seq_done   <= all_run_d;
        end
    end
endmodule

// File: tb/tb_rcc_rst_seq.sv
// Bench for rcc_rst_seq: expected rise events queued from timing formulas, checked as they occur.
module tb_rcc_rst_seq;
    localparam int unsigned ND = 4;
    localparam int unsigned CW = 8;

    typedef struct {
        int cyc;
        int code;   // dom*4 + kind: kind 0 rst_n rise, 1 clk_en rise, 2 seq_done rise
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    ev_t  sb[$];
    logic [ND-1:0] prev_rst_n;
    logic [ND-1:0] prev_clk_en;
    logic          prev_done;

    rcc_rst_seq_if #(.NUM_DOM(ND), .CNT_W(CW)) bus ();

    rcc_rst_seq #(
        .NUM_DOM(ND), .CNT_W(CW), .RST_DURATION(10), .CLK_ON_DELAY(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int fld_len(input logic [ND*CW-1:0] v, input int k);
        logic [CW-1:0] f;
        f = v[k*CW +: CW];
        return (f == 0) ? 1 : int'(f);
    endfunction

    task automatic push_ev(input int c, input int code);
        ev_t e;
        e.cyc  = c;
        e.code = code;
        sb.push_back(e);
    endtask

    // Domain d and all above restart at edge e0 using the current cfg fields.
    task automatic push_chain(input int d, input int e0);
        int t;
        t = e0;
        for (int k = d; k < ND; k++) begin
            push_ev(t + fld_len(bus.cfg_rst_dur, k), k*4);
            t = t + fld_len(bus.cfg_rst_dur, k) + fld_len(bus.cfg_clk_dly, k);
            push_ev(t, k*4 + 1);
        end
        push_ev(t, 2);
    endtask

    task automatic pop_check(input int code);
        ev_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL event: unexpected code %0d at cycle %0d, none expected", code, cyc);
        end else begin
            e = sb.pop_front();
            if (e.cyc !== cyc || e.code !== code) begin
                n_err++;
                $display("FAIL event: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                         code, cyc, e.code, e.cyc);
            end
        end
    endtask

    // One clock edge, then sample outputs away from the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int k = 0; k < ND; k++) begin
            if (bus.dom_rst_n[k] && !prev_rst_n[k]) pop_check(k*4);
            if (bus.dom_clk_en[k] && !prev_clk_en[k]) pop_check(k*4 + 1);
        end
        if (bus.seq_done && !prev_done) pop_check(2);
        n_cmp++;
        if ((bus.dom_clk_en & ~bus.dom_rst_n) !== '0 || bus.dom_busy !== ~bus.dom_clk_en
            || bus.seq_done !== &bus.dom_clk_en) begin
            n_err++;
            $display("FAIL invariant cyc %0d: rst_n=%b clk_en=%b busy=%b done=%b",
                     cyc, bus.dom_rst_n, bus.dom_clk_en, bus.dom_busy, bus.seq_done);
        end
        prev_rst_n  = bus.dom_rst_n;
        prev_clk_en = bus.dom_clk_en;
        prev_done   = bus.seq_done;
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (sb.size() != 0 && b > 0) begin
            step();
            b--;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL timeout: %0d events pending at cycle %0d, required 0", sb.size(), cyc);
            sb.delete();
        end
    endtask

    task automatic set_cfg(input int k, input int dur, input int dly);
        bus.cfg_rst_dur[k*CW +: CW] = CW'(dur);
        bus.cfg_clk_dly[k*CW +: CW] = CW'(dly);
    endtask

    task automatic check_reset_vals(input string tag);
        n_cmp++;
        if (bus.dom_rst_n !== '0 || bus.dom_clk_en !== '0 || bus.dom_busy !== '1
            || bus.seq_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s: rst_n=%b clk_en=%b busy=%b done=%b, required 0000/0000/1111/0",
                     tag, bus.dom_rst_n, bus.dom_clk_en, bus.dom_busy, bus.seq_done);
        end
    endtask

    task automatic release_and_power_on();
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        prev_rst_n  = bus.dom_rst_n;
        prev_clk_en = bus.dom_clk_en;
        prev_done   = bus.seq_done;
        for (int k = 0; k < ND; k++) begin
            push_ev(18*k + 10, k*4);
            push_ev(18*(k+1), k*4 + 1);
        end
        push_ev(72, 2);
        drain(120);
    endtask

    task automatic test_reset();
        bus.dom_rst_req = '0;
        bus.cfg_rst_dur = '1;
        bus.cfg_clk_dly = '1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_state");
        release_and_power_on();
    endtask

    task automatic test_cascade();
        set_cfg(0, 9, 9);
        set_cfg(1, 5, 3);
        set_cfg(2, 4, 2);
        set_cfg(3, 4, 2);
        bus.dom_rst_req = 4'b0010;
        step();
        bus.dom_rst_req = '0;
        n_cmp++;
        if (bus.dom_rst_n !== 4'b0001 || bus.dom_clk_en !== 4'b0001) begin
            n_err++;
            $display("FAIL cascade_drop: rst_n=%b clk_en=%b, required 0001/0001",
                     bus.dom_rst_n, bus.dom_clk_en);
        end
        push_chain(1, cyc);
        drain(100);
    endtask

    task automatic test_zero_cfg();
        set_cfg(0, 0, 0);
        bus.dom_rst_req = 4'b0001;
        step();
        bus.dom_rst_req = '0;
        check_reset_vals("zero_cfg_drop");
        push_chain(0, cyc);
        drain(100);
    endtask

    task automatic test_rereq_wait();
        int e0;
        set_cfg(2, 6, 5);
        bus.dom_rst_req = 4'b0100;
        step();
        bus.dom_rst_req = '0;
        e0 = cyc;
        push_ev(e0 + 6, 2*4);
        drain(20);
        step();
        step();
        bus.dom_rst_req = 4'b0100;
        step();
        bus.dom_rst_req = '0;
        n_cmp++;
        if (bus.dom_rst_n !== 4'b0011 || bus.dom_clk_en !== 4'b0011) begin
            n_err++;
            $display("FAIL rereq_wait: rst_n=%b clk_en=%b, required 0011/0011",
                     bus.dom_rst_n, bus.dom_clk_en);
        end
        push_chain(2, cyc);
        drain(100);
    endtask

    task automatic test_multi_req();
        set_cfg(1, 2, 2);
        bus.dom_rst_req = 4'b0110;
        step();
        bus.dom_rst_req = '0;
        n_cmp++;
        if (bus.dom_rst_n !== 4'b0001) begin
            n_err++;
            $display("FAIL multi_req: rst_n=%b, required 0001", bus.dom_rst_n);
        end
        push_chain(1, cyc);
        drain(100);
    endtask

    task automatic test_rst_mid();
        set_cfg(0, 3, 6);
        bus.dom_rst_req = 4'b0001;
        step();
        bus.dom_rst_req = '0;
        push_ev(cyc + 3, 0);
        drain(20);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        release_and_power_on();
    endtask

    task automatic test_held_req();
        set_cfg(0, 7, 2);
        bus.dom_rst_req = 4'b0001;
        for (int n = 0; n < 20; n++) begin
            step();
            n_cmp++;
            if (bus.dom_rst_n !== '0 || bus.dom_clk_en !== '0) begin
                n_err++;
                $display("FAIL held_req cycle %0d: rst_n=%b clk_en=%b, required 0000/0000",
                         n, bus.dom_rst_n, bus.dom_clk_en);
            end
        end
        bus.dom_rst_req = '0;
        push_chain(0, cyc);
        drain(120);
    endtask

    initial begin
        test_reset();
        test_cascade();
        test_zero_cfg();
        test_rereq_wait();
        test_multi_req();
        test_rst_mid();
        test_held_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
